cs_microsequencer: RTL and testbench
====================================

Name: cs_microsequencer

Overview:
- Micro-program sequencer for the control store.
- Holds the micro-PC and evaluates the next-address field of the current microinstruction against condition flags.
- Drives the select lines of the control-store address mux: 00 next, 01 jump, 10 decode.
- Performs the opcode-decode handshake with the instruction register, and optionally a micro-subroutine return stack.

Parameters:
- ADDR_WIDTH, 11, micro-address width. Must equal DECODE_WIDTH+3.
- DECODE_WIDTH, 8, opcode width used for decode dispatch.
- STACK_DEPTH, 4, return-stack entries. Used only with the optional feature.

Ports:
- CS_Sequencer_CLOCK_50  in  1  system clock. One clock; reset is asynchronous and active-low.
- CS_Sequencer_RESET_InLow  in  1  asynchronous active-low reset.
- seq_start  in  1  pulse: leave IDLE and begin executing.
- seq_stall  in  1  freeze the sequencer this cycle.
- uinst_ctrl  in  3  next-address control of the current microinstruction.
- uinst_jump  in  ADDR_WIDTH  jump/call target.
- uinst_cond_sel  in  3  condition select.
- cond_flags  in  4  datapath flags {V,C,N,Z}.
- dec_opcode  in  DECODE_WIDTH  opcode from the instruction register.
- dec_valid  in  1  opcode valid.
- dec_req  out  1  sequencer requests an opcode.
- mux_sel  out  2  select to the CS address mux.
- upc  out  ADDR_WIDTH  registered micro-PC (control-store address).
- fetch_valid  out  1  upc holds a live microinstruction.
- seq_err  out  1  sticky stack error.

Behaviour:
- Reset (async, low):
  - state=IDLE, upc=0, fetch_valid=0, dec_req=0, seq_err=0.
  - mux_sel=00, stack emptied.
  - Reset mid-operation aborts everything immediately, including a pending decode.
- States: IDLE, RUN, WAIT_DEC, HALT.
- IDLE:
  - upc holds.
  - seq_start moves to RUN next cycle with fetch_valid=1, executing at the current upc (0 after reset).
- HALT:
  - fetch_valid=0 and upc holds.
  - seq_start moves to RUN with upc=upc+1.
- RUN, when seq_stall=1:
  - Nothing changes: upc, state and stack are held, and no push/pop occurs.
  - Stall dominates every other event.
- RUN, when seq_stall=0, uinst_ctrl decoded once per cycle. The upc update takes 1 cycle.
  - 000 NEXT: upc<=upc+1, mux_sel=00. Wraps modulo 2^ADDR_WIDTH (max -> 0).
  - 001 JUMP: upc<=uinst_jump, mux_sel=01.
  - 010 DECODE:
    - If dec_valid=1: upc<={1'b1, dec_opcode, 2'b00}, mux_sel=10, stay in RUN.
    - Else: go to WAIT_DEC, fetch_valid=0, dec_req=1, upc held.
  - 011 CJUMP: if cond true, act as JUMP; else act as NEXT.
  - 100 CALL: see optional feature.
  - 101 RET: see optional feature.
  - 110 HALT: go to HALT, upc held.
  - 111 reserved: treated as NEXT.
- Condition select (uinst_cond_sel): 0 always, 1 Z, 2 N, 3 C, 4 V, 5 !Z, 6 !N, 7 !C.
- WAIT_DEC:
  - dec_req=1 and mux_sel=10.
  - When dec_valid=1 (and no stall), in the same edge: upc<=decode address, state->RUN, fetch_valid=1, dec_req=0.
  - seq_stall in WAIT_DEC holds the state and does not consume dec_valid.
- dec_req=1 only in WAIT_DEC; the opcode is consumed on the cycle where dec_req & dec_valid & !seq_stall.
- mux_sel is combinational from state and ctrl. In IDLE/HALT it is 00.

Optional Feature:
- Macro: CS_SEQ_CALL_EN.
- Defined: STACK_DEPTH-entry LIFO of return addresses.
  - CALL: push upc+1, then upc<=uinst_jump, mux_sel=01.
    - Push when full: push discarded, seq_err<=1, jump still taken.
  - RET: pop into upc, mux_sel=00 (next path carries the popped value).
    - Pop when empty: seq_err<=1, behaves as NEXT.
  - seq_err clears only on reset.
- Not defined: CALL behaves as JUMP, RET behaves as NEXT, seq_err tied 0, no stack storage.

Test Plan:
- Reset, seq_start, ctrl=NEXT for 3 cycles -> upc 0,1,2,3; fetch_valid=1 from the cycle after start; mux_sel=00.
- upc=0x7FF with NEXT -> upc=0x000. JUMP with uinst_jump=0x123 -> upc=0x123, mux_sel=01.
- DECODE with dec_valid=0 for 2 cycles, then dec_valid=1 with opcode=0x5A:
  - dec_req=1 and fetch_valid=0 while waiting.
  - Then upc=0x568, dec_req=0.
  - seq_stall asserted during the wait delays consumption by 1 cycle.
- CJUMP, cond_sel=1, target 0x040:
  - Z=1 -> upc=0x040.
  - Z=0 at upc=0x010 -> upc=0x011.
  - cond_sel=5 inverts both outcomes.
- With CS_SEQ_CALL_EN:
  - CALL 0x100 from upc=0x020, then RET -> upc 0x100, then 0x021.
  - Five nested CALLs -> seq_err=1 on the 5th, jump still taken.
  - RET on an empty stack -> seq_err=1, upc+1.
- Without the macro: CALL acts as JUMP and seq_err stays 0. Assert reset in WAIT_DEC -> IDLE, upc=0, dec_req=0 immediately.

Source files
------------

// File: rtl/cs_microsequencer.sv
`default_nettype none
// ============================================================================
// Module   : cs_microsequencer
// Purpose  : Micro-program sequencer for the control store. Holds the micro-PC,
//            evaluates the next-address control of the current microinstruction
//            against the datapath flags, drives the control-store address mux
//            select and performs the opcode-decode handshake with the IR.
// Option   : `define CS_SEQ_CALL_EN to add a STACK_DEPTH-entry return-address
//            stack (CALL/RET). Without it CALL acts as JUMP, RET as NEXT and
//            seq_err is tied low.
// Ports    : CS_Sequencer_CLOCK_50    - clock
//            CS_Sequencer_RESET_InLow - async active-low reset
//            seq_start / seq_stall    - start pulse / freeze this cycle
//            uinst_ctrl/jump/cond_sel - microinstruction next-address fields
//            cond_flags               - {V,C,N,Z}
//            dec_opcode/dec_valid     - opcode from the instruction register
//            dec_req                  - opcode request (only while waiting)
//            mux_sel                  - 00 next, 01 jump, 10 decode
//            upc / fetch_valid        - micro-PC and live-microinstruction flag
//            seq_err                  - sticky stack over/underflow
// Revision : 1.0 - initial release
// ============================================================================
module cs_microsequencer #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DECODE_WIDTH = 8,
  parameter int STACK_DEPTH  = 4
) (
  input  logic                    CS_Sequencer_CLOCK_50,
  input  logic                    CS_Sequencer_RESET_InLow,
  input  logic                    seq_start,
  input  logic                    seq_stall,
  input  logic [2:0]              uinst_ctrl,
  input  logic [ADDR_WIDTH-1:0]   uinst_jump,
  input  logic [2:0]              uinst_cond_sel,
  input  logic [3:0]              cond_flags,
  input  logic [DECODE_WIDTH-1:0] dec_opcode,
  input  logic                    dec_valid,
  output logic                    dec_req,
  output logic [1:0]              mux_sel,
  output logic [ADDR_WIDTH-1:0]   upc,
  output logic                    fetch_valid,
  output logic                    seq_err
);

  // The decode address is {1, opcode, 00}, so the widths must line up exactly.
  if ((ADDR_WIDTH != DECODE_WIDTH + 3) || (STACK_DEPTH < 1)) begin : g_param_check
    $error("cs_microsequencer: ADDR_WIDTH must equal DECODE_WIDTH+3 and STACK_DEPTH >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_DEC = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] UPC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   upc_q, upc_d;
  logic [ADDR_WIDTH-1:0]   upc_inc;
  logic [ADDR_WIDTH-1:0]   dec_addr;
  logic                    cond_true;

  assign upc_inc  = upc_q + UPC_ONE;          // wraps modulo 2^ADDR_WIDTH
  assign dec_addr = {1'b1, dec_opcode, 2'b00};

  // Flags are packed {V,C,N,Z}.
  always_comb begin
    cond_true = 1'b1;
    case (uinst_cond_sel)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = cond_flags[0];
      3'd2:    cond_true = cond_flags[1];
      3'd3:    cond_true = cond_flags[2];
      3'd4:    cond_true = cond_flags[3];
      3'd5:    cond_true = ~cond_flags[0];
      3'd6:    cond_true = ~cond_flags[1];
      default: cond_true = ~cond_flags[2];
    endcase
  end

`ifdef CS_SEQ_CALL_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [SPW-1:0]        sp_q, sp_d;
  logic                  push;
  logic                  err_q, err_d;
  logic                  stack_full, stack_empty;
  logic [IW-1:0]         push_idx, top_idx;

  assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign push_idx    = IW'(sp_q);
  assign top_idx     = IW'(sp_q - {{(SPW-1){1'b0}}, 1'b1});
`endif

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    mux_sel = 2'b00;
`ifdef CS_SEQ_CALL_EN
    sp_d    = sp_q;
    push    = 1'b0;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (seq_start && !seq_stall) state_d = ST_RUN;
      end
      ST_HALT: begin
        if (seq_start && !seq_stall) begin
          state_d = ST_RUN;
          upc_d   = upc_inc;
        end
      end
      ST_WAIT_DEC: begin
        mux_sel = 2'b10;
        // A stalled cycle must not consume the opcode.
        if (dec_valid && !seq_stall) begin
          state_d = ST_RUN;
          upc_d   = dec_addr;
        end
      end
      default: begin // ST_RUN
        // mux_sel reflects the decoded ctrl; stall only blocks the update.
        case (uinst_ctrl)
          3'b001, 3'b100: mux_sel = 2'b01;
          3'b010:         mux_sel = 2'b10;
          3'b011:         mux_sel = cond_true ? 2'b01 : 2'b00;
          default:        mux_sel = 2'b00;
        endcase
        if (!seq_stall) begin
          case (uinst_ctrl)
            3'b001: upc_d = uinst_jump;
            3'b010: begin
              if (dec_valid) upc_d = dec_addr;
              else           state_d = ST_WAIT_DEC;
            end
            3'b011: upc_d = cond_true ? uinst_jump : upc_inc;
            3'b100: begin
`ifdef CS_SEQ_CALL_EN
              // Overflowing push is dropped but the jump is still taken.
              if (stack_full) begin
                err_d = 1'b1;
              end else begin
                push = 1'b1;
                sp_d = sp_q + {{(SPW-1){1'b0}}, 1'b1};
              end
`endif
              upc_d = uinst_jump;
            end
            3'b101: begin
`ifdef CS_SEQ_CALL_EN
              if (stack_empty) begin
                err_d = 1'b1;
                upc_d = upc_inc;
              end else begin
                upc_d = stack_q[top_idx];
                sp_d  = sp_q - {{(SPW-1){1'b0}}, 1'b1};
              end
`else
              upc_d = upc_inc;
`endif
            end
            3'b110:  state_d = ST_HALT;
            default: upc_d = upc_inc; // NEXT and reserved 111
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge CS_Sequencer_CLOCK_50 or negedge CS_Sequencer_RESET_InLow) begin
    if (!CS_Sequencer_RESET_InLow) begin
      state_q <= ST_IDLE;
      upc_q   <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
    end
  end

`ifdef CS_SEQ_CALL_EN
  always_ff @(posedge CS_Sequencer_CLOCK_50 or negedge CS_Sequencer_RESET_InLow) begin
    if (!CS_Sequencer_RESET_InLow) begin
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
      if (push) stack_q[push_idx] <= upc_inc;
    end
  end

  assign seq_err = err_q;
`else
  assign seq_err = 1'b0;
`endif

  assign upc         = upc_q;
  assign fetch_valid = (state_q == ST_RUN);
  assign dec_req     = (state_q == ST_WAIT_DEC);

endmodule
`default_nettype wire

// File: tb/tb_cs_microsequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cs_microsequencer
// Purpose  : Self-checking bench for cs_microsequencer. Directed scenarios
//            followed by randomized microinstruction streams, compared against
//            a behavioural model (queue-based return stack) each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cs_microsequencer;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << AW) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;
  localparam int M_HALT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          seq_start, seq_stall;
  logic [2:0]    uinst_ctrl, uinst_cond_sel;
  logic [AW-1:0] uinst_jump;
  logic [3:0]    cond_flags;
  logic [DW-1:0] dec_opcode;
  logic          dec_valid;
  logic          dec_req, fetch_valid, seq_err;
  logic [1:0]    mux_sel;
  logic [AW-1:0] upc;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model
  int m_mode;
  int m_upc;
  bit m_err;
  int m_stack[$];

  always #5 clk = ~clk;

  cs_microsequencer #(.ADDR_WIDTH(AW), .DECODE_WIDTH(DW), .STACK_DEPTH(DEPTH)) dut (
    .CS_Sequencer_CLOCK_50   (clk),
    .CS_Sequencer_RESET_InLow(rst_n),
    .seq_start               (seq_start),
    .seq_stall               (seq_stall),
    .uinst_ctrl              (uinst_ctrl),
    .uinst_jump              (uinst_jump),
    .uinst_cond_sel          (uinst_cond_sel),
    .cond_flags              (cond_flags),
    .dec_opcode              (dec_opcode),
    .dec_valid               (dec_valid),
    .dec_req                 (dec_req),
    .mux_sel                 (mux_sel),
    .upc                     (upc),
    .fetch_valid             (fetch_valid),
    .seq_err                 (seq_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cond_eval(input int sel, input logic [3:0] f);
    // f = {V,C,N,Z}
    case (sel)
      0: return 1'b1;
      1: return f[0];
      2: return f[1];
      3: return f[2];
      4: return f[3];
      5: return !f[0];
      6: return !f[1];
      default: return !f[2];
    endcase
  endfunction

  function automatic int exp_mux();
    if (m_mode == M_WAIT) return 2;
    if (m_mode != M_RUN) return 0;
    case (int'(uinst_ctrl))
      1, 4: return 1;
      2:    return 2;
      3:    return cond_eval(int'(uinst_cond_sel), cond_flags) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_upc  = 0;
    m_err  = 1'b0;
    m_stack.delete();
  endtask

  task automatic check_outputs();
    chk("upc", 32'(upc), 32'(m_upc));
    chk("fetch_valid", 32'(fetch_valid), 32'(m_mode == M_RUN));
    chk("dec_req", 32'(dec_req), 32'(m_mode == M_WAIT));
    chk("mux_sel", 32'(mux_sel), 32'(exp_mux()));
    chk("seq_err", 32'(seq_err), 32'(m_err));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input int ctrl, input int jmp, input int csel, input int fl,
                      input int op, input bit dv, input bit stall, input bit start);
    int n_mode, n_upc, inc, daddr;
    bit n_err;
    seq_start      = start;
    seq_stall      = stall;
    uinst_ctrl     = 3'(ctrl);
    uinst_jump     = AW'(jmp);
    uinst_cond_sel = 3'(csel);
    cond_flags     = 4'(fl);
    dec_opcode     = DW'(op);
    dec_valid      = dv;
    #2;
    check_outputs();
    n_mode = m_mode;
    n_upc  = m_upc;
    n_err  = m_err;
    inc    = (m_upc + 1) & MASK;
    daddr  = (1 << (AW - 1)) | ((op & 'hFF) << 2);
    if (!stall) begin
      case (m_mode)
        M_IDLE: if (start) n_mode = M_RUN;
        M_HALT: if (start) begin n_mode = M_RUN; n_upc = inc; end
        M_WAIT: if (dv) begin n_mode = M_RUN; n_upc = daddr; end
        default: begin
          case (ctrl)
            1: n_upc = jmp & MASK;
            2: if (dv) n_upc = daddr; else n_mode = M_WAIT;
            3: n_upc = cond_eval(csel, 4'(fl)) ? (jmp & MASK) : inc;
            4: begin
`ifdef CS_SEQ_CALL_EN
              if (m_stack.size() < DEPTH) m_stack.push_back(inc);
              else n_err = 1'b1;
`endif
              n_upc = jmp & MASK;
            end
            5: begin
`ifdef CS_SEQ_CALL_EN
              if (m_stack.size() > 0) n_upc = m_stack.pop_back();
              else begin n_err = 1'b1; n_upc = inc; end
`else
              n_upc = inc;
`endif
            end
            6: n_mode = M_HALT;
            default: n_upc = inc;
          endcase
        end
      endcase
    end
    @(posedge clk);
    #1;
    m_mode = n_mode;
    m_upc  = n_upc;
    m_err  = n_err;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    seq_start = 0; seq_stall = 0; uinst_ctrl = 0; uinst_jump = 0;
    uinst_cond_sel = 0; cond_flags = 0; dec_opcode = 0; dec_valid = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    chk("reset_upc", 32'(upc), 32'd0);
    rst_n = 1'b1;

    // Start, then NEXT x3
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("start_fv", 32'(fetch_valid), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("next3_upc", 32'(upc), 32'h3);

    // Wrap and JUMP
    step(1, 'h7FF, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_upc", 32'(upc), 32'h0);
    step(1, 'h123, 0, 0, 0, 0, 0, 0);
    chk("jump_upc", 32'(upc), 32'h123);

    // DECODE handshake with a stalled cycle during the wait
    step(2, 0, 0, 0, 'h5A, 0, 0, 0);
    chk("wait_dec_req", 32'(dec_req), 32'd1);
    step(2, 0, 0, 0, 'h5A, 0, 0, 0);
    step(2, 0, 0, 0, 'h5A, 1, 1, 0);
    chk("stall_wait_dec_req", 32'(dec_req), 32'd1);
    step(2, 0, 0, 0, 'h5A, 1, 0, 0);
    chk("dec_upc", 32'(upc), 32'h568);
    chk("dec_req_clear", 32'(dec_req), 32'd0);

    // CJUMP on Z and !Z
    step(3, 'h040, 1, 'b0001, 0, 0, 0, 0);
    chk("cj_z1", 32'(upc), 32'h040);
    step(1, 'h010, 0, 0, 0, 0, 0, 0);
    step(3, 'h040, 1, 'b0000, 0, 0, 0, 0);
    chk("cj_z0", 32'(upc), 32'h011);
    step(3, 'h040, 5, 'b0000, 0, 0, 0, 0);
    chk("cj_nz_z0", 32'(upc), 32'h040);
    step(1, 'h010, 0, 0, 0, 0, 0, 0);
    step(3, 'h040, 5, 'b0001, 0, 0, 0, 0);
    chk("cj_nz_z1", 32'(upc), 32'h011);

    // HALT then restart
    step(6, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("halt_restart", 32'(upc), 32'h012);

    // CALL / RET
    step(1, 'h020, 0, 0, 0, 0, 0, 0);
    step(4, 'h100, 0, 0, 0, 0, 0, 0);
    chk("call_upc", 32'(upc), 32'h100);
    step(5, 0, 0, 0, 0, 0, 0, 0);
`ifdef CS_SEQ_CALL_EN
    chk("ret_upc", 32'(upc), 32'h021);
    for (int i = 0; i < 4; i++) step(4, 'h200 + i * 16, 0, 0, 0, 0, 0, 0);
    chk("four_calls_err", 32'(seq_err), 32'd0);
    step(4, 'h300, 0, 0, 0, 0, 0, 0);
    chk("overflow_err", 32'(seq_err), 32'd1);
    chk("overflow_jump", 32'(upc), 32'h300);
    for (int i = 0; i < 4; i++) step(5, 0, 0, 0, 0, 0, 0, 0);
    step(5, 0, 0, 0, 0, 0, 0, 0);
    chk("underflow_err", 32'(seq_err), 32'd1);
`else
    chk("ret_as_next", 32'(upc), 32'h101);
    chk("no_err", 32'(seq_err), 32'd0);
`endif

    // Reset while waiting for an opcode
    step(2, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_reset_wait", 32'(dec_req), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_dec_req", 32'(dec_req), 32'd0);
    chk("rst_upc", 32'(upc), 32'd0);
    chk("rst_fv", 32'(fetch_valid), 32'd0);
    chk("rst_mux", 32'(mux_sel), 32'd0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized streams
    for (int i = 0; i < 600; i++) begin
      int r, ctrl;
      r = int'($urandom_range(0, 15));
      ctrl = (r == 15) ? 6 : (((r & 7) == 6) ? 0 : (r & 7));
      step(ctrl, int'($urandom_range(0, MASK)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0));
    end
    #2;
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
